execute_unit: RTL and testbench

Sequential execute stage directly downstream of the 16x16 register file. It consumes the two read-port operands A and B, performs single-cycle logic/arithmetic or multi-cycle shift/multiply operations, and returns a one-cycle write-back (D, DEST_SEL, LOAD_EN) to the register file write port. BUSY tells the controller when a new operation can be issued.

---
 rtl/execute_pkg.sv | 42 ++++
 rtl/execute_mul_seq.sv | 51 +++++
 rtl/execute_unit.sv | 147 ++++++++++++++
 tb/tb_execute_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared widths, opcodes, FSM states and ALU helper for the execute stage
package execute_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_NOT = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8,
        OP_MUL = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_WB
    } state_e;

    // Returns {carry, result}; shifts by zero fall through to the default and pass A unchanged.
    function automatic logic [DATA_W:0] alu_op(input logic [3:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  alu_op = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu_op = {1'b0, a} - {1'b0, b};
            OP_AND:  alu_op = {1'b0, a & b};
            OP_OR:   alu_op = {1'b0, a | b};
            OP_XOR:  alu_op = {1'b0, a ^ b};
            OP_NOT:  alu_op = {1'b0, ~a};
            default: alu_op = {1'b0, a};
        endcase
    endfunction

endpackage

// File: rtl/execute_mul_seq.sv
// rtl/execute_mul_seq.sv - 16-cycle shift-add multiplier with start/done and 32-bit product
module mul_seq
    import execute_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_next;
    logic [3:0]          count;
    logic                active;

    // product is the accumulator including this cycle's partial term, so the
    // final value is usable on the same edge that retires the last multiplier bit.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = active && (count == 4'd15);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 4'd1;
            if (count == 4'd15) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - execute stage: single-cycle ALU, serial shifter and sequenced multiplier
module execute_unit
    import execute_pkg::*;
(
    input  logic              C,
    input  logic              RST_N,
    input  logic              START,
    input  logic [3:0]        OPCODE,
    input  logic [IDX_W-1:0]  DEST,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] D,
    output logic [IDX_W-1:0]  DEST_SEL,
    output logic              LOAD_EN,
    output logic              BUSY,
    output logic              FLAG_Z,
    output logic              FLAG_N,
    output logic              FLAG_C
);

    state_e              state;
    logic [3:0]          op_q;
    logic [IDX_W-1:0]    dest_q;
    logic [DATA_W-1:0]   work;
    logic [3:0]          cnt;

    logic                accept;
    logic                is_shift;
    logic [DATA_W:0]     alu_res;
    logic [DATA_W-1:0]   shift_val;
    logic                shift_out;
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    logic                wb_fire;
    logic [DATA_W-1:0]   wb_val;
    logic                wb_c;
    logic [IDX_W-1:0]    wb_dest;

    assign BUSY      = (state != ST_IDLE);
    assign accept    = START && (state == ST_IDLE);
    assign is_shift  = (OPCODE == OP_SHL) || (OPCODE == OP_SHR);
    assign mul_start = accept && (OPCODE == OP_MUL);

    mul_seq u_mul (
        .clk     (C),
        .resetn  (RST_N),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res   = alu_op(OPCODE, A, B);
        shift_val = (op_q == OP_SHL) ? {work[DATA_W-2:0], 1'b0} : {1'b0, work[DATA_W-1:1]};
        shift_out = (op_q == OP_SHL) ? work[DATA_W-1] : work[0];
    end

    // One write-back path shared by the three ways of reaching WB.
    always_comb begin
        wb_fire = 1'b0;
        wb_val  = alu_res[DATA_W-1:0];
        wb_c    = alu_res[DATA_W];
        wb_dest = dest_q;
        case (state)
            ST_IDLE: begin
                wb_fire = accept && (OPCODE < OP_MUL) && !(is_shift && (B[3:0] != 4'd0));
                wb_dest = DEST;
            end
            ST_SHIFT: begin
                wb_fire = (cnt == 4'd1);
                wb_val  = shift_val;
                wb_c    = shift_out;
            end
            ST_MUL: begin
                wb_fire = mul_done;
                wb_val  = mul_product[DATA_W-1:0];
                wb_c    = |mul_product[2*DATA_W-1:DATA_W];
            end
            default: begin
                wb_fire = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            dest_q   <= '0;
            work     <= '0;
            cnt      <= '0;
            D        <= '0;
            DEST_SEL <= '0;
            LOAD_EN  <= 1'b0;
            FLAG_Z   <= 1'b0;
            FLAG_N   <= 1'b0;
            FLAG_C   <= 1'b0;
        end else begin
            LOAD_EN <= wb_fire;
            if (wb_fire) begin
                D        <= wb_val;
                DEST_SEL <= wb_dest;
                FLAG_Z   <= (wb_val == '0);
                FLAG_N   <= wb_val[DATA_W-1];
                FLAG_C   <= wb_c;
            end
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        op_q   <= OPCODE;
                        dest_q <= DEST;
                        work   <= A;
                        cnt    <= B[3:0];
                        if (OPCODE == OP_MUL) begin
                            state <= ST_MUL;
                        end else if (is_shift && (B[3:0] != 4'd0)) begin
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_WB;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt == 4'd1) begin
                        state <= ST_WB;
                    end else begin
                        work <= shift_val;
                        cnt  <= cnt - 4'd1;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state <= ST_WB;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - self-checking bench for execute_unit with cycle model and directed vectors
module tb_execute_unit;

    logic        C = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [3:0]  OPCODE = '0;
    logic [3:0]  DEST = '0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] D;
    logic [3:0]  DEST_SEL;
    logic        LOAD_EN;
    logic        BUSY;
    logic        FLAG_Z;
    logic        FLAG_N;
    logic        FLAG_C;

    int vectors = 0;
    int fails   = 0;

    execute_unit dut (
        .C        (C),
        .RST_N    (RST_N),
        .START    (START),
        .OPCODE   (OPCODE),
        .DEST     (DEST),
        .A        (A),
        .B        (B),
        .D        (D),
        .DEST_SEL (DEST_SEL),
        .LOAD_EN  (LOAD_EN),
        .BUSY     (BUSY),
        .FLAG_Z   (FLAG_Z),
        .FLAG_N   (FLAG_N),
        .FLAG_C   (FLAG_C)
    );

    initial forever #5 C = ~C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: an accepted op keeps the unit busy for its latency; the
    // write-back shows in the last busy cycle.
    int          m_busy  = 0;
    bit          m_load  = 0;
    bit          m_write = 0;
    logic [15:0] m_res   = '0;
    logic [3:0]  m_wdest = '0;
    logic        m_cres  = 1'b0;
    logic [15:0] m_d     = '0;
    logic [3:0]  m_dest  = '0;
    logic        m_z = 0, m_n = 0, m_c = 0;
    bit          chk_en  = 0;

    always @(posedge C) begin
        if (!RST_N) begin
            m_busy = 0; m_load = 0; m_write = 0;
            m_d = '0; m_dest = '0; m_z = 0; m_n = 0; m_c = 0;
            chk_en = 1;
        end else begin
            if (m_busy > 0) begin
                m_busy--;
            end else if (START) begin
                logic [31:0] a32, b32, p;
                int n;
                a32 = {16'd0, A};
                b32 = {16'd0, B};
                n = int'(B & 16'hF);
                m_write = 1; m_busy = 1; m_cres = 0; m_wdest = DEST;
                case (OPCODE)
                    4'd0: m_res = A;
                    4'd1: begin p = a32 + b32; m_res = p[15:0]; m_cres = p[16]; end
                    4'd2: begin m_res = A - B; m_cres = (A < B); end
                    4'd3: m_res = A & B;
                    4'd4: m_res = A | B;
                    4'd5: m_res = A ^ B;
                    4'd6: m_res = ~A;
                    4'd7: begin
                        p = a32 << n; m_res = p[15:0];
                        if (n > 0) begin p = a32 >> (16 - n); m_cres = p[0]; m_busy = 1 + n; end
                    end
                    4'd8: begin
                        p = a32 >> n; m_res = p[15:0];
                        if (n > 0) begin p = a32 >> (n - 1); m_cres = p[0]; m_busy = 1 + n; end
                    end
                    4'd9: begin p = a32 * b32; m_res = p[15:0]; m_cres = (p[31:16] != 0); m_busy = 17; end
                    default: m_write = 0;
                endcase
            end
            m_load = (m_busy == 1) && m_write;
            if (m_load) begin
                m_d = m_res; m_dest = m_wdest;
                m_z = (m_res == 0); m_n = m_res[15]; m_c = m_cres;
            end
        end
    end

    always @(negedge C) begin
        if (chk_en) begin
            check("model_busy",    {31'd0, BUSY},    {31'd0, m_busy > 0});
            check("model_load_en", {31'd0, LOAD_EN}, {31'd0, m_load});
            check("model_d",       {16'd0, D},       {16'd0, m_d});
            check("model_dest",    {28'd0, DEST_SEL},{28'd0, m_dest});
            check("model_flags",   {29'd0, FLAG_Z, FLAG_N, FLAG_C}, {29'd0, m_z, m_n, m_c});
        end
    end

    // Issue at a negedge while idle, wait for LOAD_EN, check literals, then let WB retire.
    task automatic run_op(input string name, input logic [3:0] op, input logic [3:0] dest,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_d,
                          input int exp_lat, input logic ez, input logic en, input logic ec,
                          input bit pulse);
        int lat;
        bit seen;
        OPCODE = op; DEST = dest; A = a; B = b; START = 1'b1;
        @(posedge C);
        @(negedge C);
        START = 1'b0; A = 16'hDEAD; B = 16'hBEE3; OPCODE = 4'd1; DEST = 4'hE;
        lat = 1; seen = 0;
        while (!seen && lat <= 40) begin
            if (LOAD_EN === 1'b1) begin
                seen = 1;
            end else begin
                START = (pulse && lat == 5);
                @(negedge C);
                lat++;
            end
        end
        START = 1'b0;
        check({name, "_latency"}, seen ? 32'(lat) : 32'hFFFFFFFF, 32'(exp_lat));
        if (seen) begin
            check({name, "_d"},     {16'd0, D},        {16'd0, exp_d});
            check({name, "_dest"},  {28'd0, DEST_SEL}, {28'd0, dest});
            check({name, "_flags"}, {29'd0, FLAG_Z, FLAG_N, FLAG_C}, {29'd0, ez, en, ec});
        end
        @(negedge C);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  dest;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        int          lat;
        logic        z, n, c;
    } vec_t;

    vec_t vecs[$] = '{
        '{4'd3, 4'd6,  16'hF0F0, 16'h0FF0, 16'h00F0, 1,  0, 0, 0},
        '{4'd4, 4'd8,  16'h1200, 16'h0034, 16'h1234, 1,  0, 0, 0},
        '{4'd5, 4'd9,  16'hFFFF, 16'h0F0F, 16'hF0F0, 1,  0, 1, 0},
        '{4'd6, 4'd10, 16'h0000, 16'h1234, 16'hFFFF, 1,  0, 1, 0},
        '{4'd8, 4'd11, 16'h0003, 16'h0001, 16'h0001, 2,  0, 0, 1},
        '{4'd7, 4'd12, 16'h0001, 16'h000F, 16'h8000, 16, 0, 1, 0},
        '{4'd8, 4'd13, 16'hC000, 16'h00FF, 16'h0001, 16, 0, 0, 1},
        '{4'd9, 4'd14, 16'h0012, 16'h0034, 16'h03A8, 17, 0, 0, 0},
        '{4'd1, 4'd1,  16'h1234, 16'h1111, 16'h2345, 1,  0, 0, 0},
        '{4'd0, 4'd15, 16'h5555, 16'hFFFF, 16'h5555, 1,  0, 0, 0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vectors);
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        repeat (2) @(negedge C);
        check("reset_busy",    {31'd0, BUSY},    32'd0);
        check("reset_load_en", {31'd0, LOAD_EN}, 32'd0);
        check("reset_d",       {16'd0, D},       32'd0);
        RST_N = 1'b1;
        @(negedge C);

        run_op("add_wrap", 4'd1, 4'd3, 16'hFFFF, 16'h0001, 16'h0000, 1,  1, 0, 1, 0);
        run_op("sub_borrow", 4'd2, 4'd7, 16'h0002, 16'h0005, 16'hFFFD, 1, 0, 1, 1, 0);
        run_op("shl_4",    4'd7, 4'd1, 16'h8001, 16'h0004, 16'h0010, 5,  0, 0, 0, 0);
        run_op("shl_0",    4'd7, 4'd2, 16'h8001, 16'h0000, 16'h8001, 1,  0, 1, 0, 0);
        run_op("mul_ovf",  4'd9, 4'd4, 16'h0300, 16'h0100, 16'h0000, 17, 1, 0, 1, 1);

        run_op("add_z",    4'd1, 4'd5, 16'hFFFF, 16'h0001, 16'h0000, 1,  1, 0, 1, 0);
        OPCODE = 4'd12; DEST = 4'd2; A = 16'h1111; B = 16'h2222; START = 1'b1;
        @(posedge C);
        @(negedge C);
        START = 1'b0;
        check("nop_busy",    {31'd0, BUSY},    32'd1);
        check("nop_load_en", {31'd0, LOAD_EN}, 32'd0);
        @(negedge C);
        check("nop_busy_end", {31'd0, BUSY},  32'd0);
        check("nop_flags",   {29'd0, FLAG_Z, FLAG_N, FLAG_C}, 32'd5);
        check("nop_d_hold",  {16'd0, D},      32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].dest, vecs[i].a, vecs[i].b,
                   vecs[i].d, vecs[i].lat, vecs[i].z, vecs[i].n, vecs[i].c, 0);
        end

        OPCODE = 4'd9; DEST = 4'd6; A = 16'h00FF; B = 16'h00FF; START = 1'b1;
        @(posedge C);
        @(negedge C);
        START = 1'b0;
        repeat (7) @(negedge C);
        RST_N = 1'b0;
        @(posedge C);
        @(negedge C);
        RST_N = 1'b1;
        check("rst_mul_busy",    {31'd0, BUSY},    32'd0);
        check("rst_mul_load_en", {31'd0, LOAD_EN}, 32'd0);
        check("rst_mul_d",       {16'd0, D},       32'd0);
        check("rst_mul_dest",    {28'd0, DEST_SEL}, 32'd0);
        check("rst_mul_flags",   {29'd0, FLAG_Z, FLAG_N, FLAG_C}, 32'd0);
        repeat (20) @(negedge C);
        check("rst_mul_no_wb",   {31'd0, LOAD_EN}, 32'd0);
        run_op("mov_after_rst", 4'd0, 4'd9, 16'h1234, 16'h0000, 16'h1234, 1, 0, 0, 0, 0);

        repeat (3) @(negedge C);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
